// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_RESP
  } lsu_state_t;

  // Bit-lane mask of an access of the given size at byte offset 0.
  function automatic logic [31:0] lane_mask(input size_t size);
    case (size)
      SIZE_B:  return 32'h0000_00ff;
      SIZE_H:  return 32'h0000_ffff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

  // Lane mask placed at its byte offset; low word is beat0, high word is
  // whatever spilled into the next word (beat1 of a split access).
  function automatic logic [63:0] rw_mask(input size_t size, input logic [1:0] off);
    return {32'h0, lane_mask(size)} << {off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Merges one or two read beats, aligns the addressed bytes to bit 0 and
// sign/zero-extends to 32 bits. Purely combinational.
module lsu_load_extract (
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] r0,
  input  logic [31:0] r1,
  output logic [31:0] data
);

  logic [63:0] merged;
  logic [31:0] word;

  // Shift the two-beat window down by the byte offset, then extend.
  always_comb begin
    merged = {r1, r0} >> {off, 3'b000};
    word   = merged[31:0];
    case (size)
      2'd0:    data = {(uns ? 24'h0 : {24{word[7]}}), word[7:0]};
      2'd1:    data = {(uns ? 16'h0 : {16{word[15]}}), word[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one core request at a time, word-aligned bus beats
// with bit-lane masks, aligned/extended load return.
// Build option LSU_MISALIGNED_SPLIT_EN: split misaligned accesses into two
// beats; when undefined they are rejected with an error and no bus beat.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_bus_valid,
  input  logic        i_bus_ready,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_mask,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  lsu_state_t  state, state_nx;
  logic        we_q, uns_q, err_q;
  logic [31:0] addr_q, wdata_q, rd0_q, rdata_q;
  logic [1:0]  size_q;
  logic [CW-1:0] cnt;
  logic        to_err, load_done, last0, timed_out;
  logic        illegal, mis;
  logic [63:0] m64, w64;
  logic [31:0] base, wrot, ext_r0, ext_r1, ext_data;
  logic        beat1;

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic split_q;
  assign last0  = !split_q;
  assign ext_r1 = (state == ST_WAIT1) ? i_bus_rdata : 32'h0;
`else
  assign last0  = 1'b1;
  assign ext_r1 = 32'h0;
`endif

  // Request decode (from live inputs, used on accept).
  assign illegal = (i_req_size == 2'd3);
  assign mis     = ((i_req_size == 2'd1) && (i_req_addr[1:0] == 2'd3)) ||
                   ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'd0));

  // Beat fields derived from the latched request.
  assign m64   = rw_mask(size_t'(size_q), addr_q[1:0]);
  assign w64   = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
  assign wrot  = w64[31:0] | w64[63:32];
  assign base  = {addr_q[31:2], 2'b00};
  assign beat1 = (state == ST_ISSUE1);

  assign o_req_ready = (state == ST_IDLE);
  assign o_bus_valid = (state == ST_ISSUE0) || beat1;
  assign o_bus_we    = o_bus_valid & we_q;
  assign o_bus_addr  = o_bus_valid ? (beat1 ? base + 32'd4 : base) : 32'h0;
  assign o_bus_mask  = o_bus_valid ? (beat1 ? m64[63:32] : m64[31:0]) : 32'h0;
  assign o_bus_wdata = o_bus_we ? wrot : 32'h0;
  assign o_rsp_valid = (state == ST_RESP);
  assign o_rsp_err   = o_rsp_valid & err_q;
  assign o_rsp_rdata = o_rsp_valid ? rdata_q : 32'h0;

  assign timed_out = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign ext_r0    = (state == ST_WAIT0) ? i_bus_rdata : rd0_q;

  lsu_load_extract u_extract (
    .off  (addr_q[1:0]),
    .size (size_q),
    .uns  (uns_q),
    .r0   (ext_r0),
    .r1   (ext_r1),
    .data (ext_data)
  );

  // Next-state logic; to_err marks an error exit into RESP.
  always_comb begin
    state_nx  = state;
    to_err    = 1'b0;
    load_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req_valid) begin
          if (illegal) begin
            state_nx = ST_RESP;
            to_err   = 1'b1;
          end
`ifndef LSU_MISALIGNED_SPLIT_EN
          else if (mis) begin
            state_nx = ST_RESP;
            to_err   = 1'b1;
          end
`endif
          else state_nx = ST_ISSUE0;
        end
      end
      ST_ISSUE0: begin
        if (i_bus_ready) begin
          if (!we_q)      state_nx = ST_WAIT0;
          else if (last0) state_nx = ST_RESP;
          else            state_nx = ST_ISSUE1;
        end else if (timed_out) begin
          state_nx = ST_RESP;
          to_err   = 1'b1;
        end
      end
      ST_WAIT0: begin
        if (i_bus_rvalid) begin
          load_done = last0;
          state_nx  = last0 ? ST_RESP : ST_ISSUE1;
        end else if (timed_out) begin
          state_nx = ST_RESP;
          to_err   = 1'b1;
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ST_ISSUE1: begin
        if (i_bus_ready) state_nx = we_q ? ST_RESP : ST_WAIT1;
        else if (timed_out) begin
          state_nx = ST_RESP;
          to_err   = 1'b1;
        end
      end
      ST_WAIT1: begin
        if (i_bus_rvalid) begin
          load_done = 1'b1;
          state_nx  = ST_RESP;
        end else if (timed_out) begin
          state_nx = ST_RESP;
          to_err   = 1'b1;
        end
      end
`endif
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, request latch, beat0 read capture, response data and wait counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'd0;
      rd0_q   <= 32'h0;
      rdata_q <= 32'h0;
      cnt     <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + 1'b1;
      if (state == ST_IDLE) begin
        if (i_req_valid) begin
          we_q    <= i_req_we;
          uns_q   <= i_req_unsigned;
          addr_q  <= i_req_addr;
          wdata_q <= i_req_wdata;
          size_q  <= i_req_size;
          err_q   <= to_err;
          rdata_q <= 32'h0;
`ifdef LSU_MISALIGNED_SPLIT_EN
          split_q <= mis;
`endif
        end
      end else begin
        if (to_err) err_q <= 1'b1;
        if ((state == ST_WAIT0) && i_bus_rvalid) rd0_q <= i_bus_rdata;
        if (load_done) rdata_q <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected beats/responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_lsu_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] mask;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_valid, bus_we;
  logic        bus_ready = 1'b1;
  logic [31:0] bus_addr, bus_mask, bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0, errors = 0, valid_cycles = 0;
  bit          rd_en = 1'b1;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(255)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_size(req_size), .i_req_unsigned(req_uns),
    .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_bus_valid(bus_valid), .i_bus_ready(bus_ready), .o_bus_we(bus_we),
    .o_bus_addr(bus_addr), .o_bus_mask(bus_mask), .o_bus_wdata(bus_wdata),
    .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata)
  );

  // Monitor: compare every accepted beat and every response against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_valid) valid_cycles++;
      if (bus_valid && bus_ready) begin
        beat_t got, exp;
        got = '{bus_we, bus_addr, bus_mask, bus_wdata};
        checks++;
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got we=%0b addr=%h mask=%h wdata=%h", got.we, got.addr, got.mask, got.wdata);
        end else begin
          exp = beat_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL beat got we=%0b addr=%h mask=%h wdata=%h exp we=%0b addr=%h mask=%h wdata=%h",
                     got.we, got.addr, got.mask, got.wdata, exp.we, exp.addr, exp.mask, exp.wdata);
          end
        end
      end
      if (rsp_valid) begin
        rsp_t got, exp;
        got = '{rsp_rdata, rsp_err};
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got rdata=%h err=%0b", got.rdata, got.err);
        end else begin
          exp = rsp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL rsp got rdata=%h err=%0b exp rdata=%h err=%0b", got.rdata, got.err, exp.rdata, exp.err);
          end
        end
      end
    end
  end

  // Bus read responder: one cycle after a read beat is accepted, return the next queued word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rd_en && bus_valid && bus_ready && !bus_we) begin
        @(posedge clk);
        #1;
        bus_rvalid = 1'b1;
        bus_rdata  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic push_beat(input logic we, input logic [31:0] addr, input logic [31:0] mask, input logic [31:0] wdata);
    beat_q.push_back('{we, addr, mask, wdata});
  endtask

  task automatic push_rsp(input logic [31:0] rdata, input logic err);
    rsp_q.push_back('{rdata, err});
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    int n;
    req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || beat_q.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_q.size() != 0 || beat_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got pending beats=%0d rsps=%0d exp 0", name, beat_q.size(), rsp_q.size());
      beat_q.delete();
      rsp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_bus_mask", bus_mask, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SB in-word
    push_beat(1'b1, 32'h100, 32'h0000ff00, 32'h0000ab00);
    push_rsp(32'h0, 1'b0);
    issue(1'b1, 32'h101, 2'd0, 1'b0, 32'h000000ab);
    wait_idle("sb");

    // LH signed / unsigned at offset 2
    push_beat(1'b0, 32'h100, 32'hffff0000, 32'h0);
    rd_q.push_back(32'h8001_0000);
    push_rsp(32'hffff8001, 1'b0);
    issue(1'b0, 32'h102, 2'd1, 1'b0, 32'h0);
    wait_idle("lh");
    push_beat(1'b0, 32'h100, 32'hffff0000, 32'h0);
    rd_q.push_back(32'h8001_0000);
    push_rsp(32'h00008001, 1'b0);
    issue(1'b0, 32'h102, 2'd1, 1'b1, 32'h0);
    wait_idle("lhu");

    // SH at offset 1 stays in-word
    push_beat(1'b1, 32'h100, 32'h00ffff00, 32'h00123400);
    push_rsp(32'h0, 1'b0);
    issue(1'b1, 32'h101, 2'd1, 1'b0, 32'h00001234);
    wait_idle("sh_off1");

    // LB / LBU at offset 3
    push_beat(1'b0, 32'h200, 32'hff000000, 32'h0);
    rd_q.push_back(32'h8500_0000);
    push_rsp(32'hffffff85, 1'b0);
    issue(1'b0, 32'h203, 2'd0, 1'b0, 32'h0);
    wait_idle("lb");
    push_beat(1'b0, 32'h200, 32'hff000000, 32'h0);
    rd_q.push_back(32'h8500_0000);
    push_rsp(32'h00000085, 1'b0);
    issue(1'b0, 32'h203, 2'd0, 1'b1, 32'h0);
    wait_idle("lbu");

    // Aligned LW ignores unsigned
    push_beat(1'b0, 32'h104, 32'hffffffff, 32'h0);
    rd_q.push_back(32'hdeadbeef);
    push_rsp(32'hdeadbeef, 1'b0);
    issue(1'b0, 32'h104, 2'd2, 1'b1, 32'h0);
    wait_idle("lw");

    // Misaligned accesses
`ifdef LSU_MISALIGNED_SPLIT_EN
    push_beat(1'b0, 32'h100, 32'hff000000, 32'h0);
    push_beat(1'b0, 32'h104, 32'h00ffffff, 32'h0);
    rd_q.push_back(32'h11aabbcc);
    rd_q.push_back(32'h55443322);
    push_rsp(32'h44332211, 1'b0);
    issue(1'b0, 32'h103, 2'd2, 1'b0, 32'h0);
    wait_idle("lw_split");
    push_beat(1'b0, 32'h100, 32'hff000000, 32'h0);
    push_beat(1'b0, 32'h104, 32'h000000ff, 32'h0);
    rd_q.push_back(32'hab000000);
    rd_q.push_back(32'h000000cd);
    push_rsp(32'hffffcdab, 1'b0);
    issue(1'b0, 32'h103, 2'd1, 1'b0, 32'h0);
    wait_idle("lh_split");
    push_beat(1'b1, 32'hfffffffc, 32'hffff0000, 32'hbabecafe);
    push_beat(1'b1, 32'h00000000, 32'h0000ffff, 32'hbabecafe);
    push_rsp(32'h0, 1'b0);
    issue(1'b1, 32'hfffffffe, 2'd2, 1'b0, 32'hcafebabe);
    wait_idle("sw_wrap");
`else
    push_rsp(32'h0, 1'b1);
    issue(1'b0, 32'h103, 2'd2, 1'b0, 32'h0);
    wait_idle("lw_mis");
    push_rsp(32'h0, 1'b1);
    issue(1'b0, 32'h103, 2'd1, 1'b0, 32'h0);
    wait_idle("lh_mis");
    push_rsp(32'h0, 1'b1);
    issue(1'b1, 32'hfffffffe, 2'd2, 1'b0, 32'hcafebabe);
    wait_idle("sw_mis");
`endif

    // Illegal size: error, no beat
    push_rsp(32'h0, 1'b1);
    issue(1'b1, 32'h100, 2'd3, 1'b0, 32'h12345678);
    wait_idle("size3");

    // Bus never ready: abort after 255 cycles of o_bus_valid, stale rvalid ignored
    bus_ready = 1'b0;
    valid_cycles = 0;
    push_rsp(32'h0, 1'b1);
    issue(1'b0, 32'h200, 2'd2, 1'b0, 32'h0);
    wait_idle("timeout");
    chk("timeout_valid_cycles", valid_cycles, 32'd255);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5a5a5a5a;
    repeat (2) @(posedge clk);
    #1 bus_rvalid = 1'b0;
    bus_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset while waiting on read data
    rd_en = 1'b0;
    push_beat(1'b0, 32'h300, 32'hffffffff, 32'h0);
    issue(1'b0, 32'h300, 2'd2, 1'b0, 32'h0);
    wait_idle("rst_beat");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'h0, req_ready}, 32'h1);
    chk("midrst_bus_valid", {31'h0, bus_valid}, 32'h0);
    chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    chk("postrst_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    push_beat(1'b0, 32'h104, 32'hffffffff, 32'h0);
    rd_q.push_back(32'h0badf00d);
    push_rsp(32'h0badf00d, 1'b0);
    issue(1'b0, 32'h104, 2'd2, 1'b0, 32'h0);
    wait_idle("postrst_lw");

    repeat (3) @(posedge clk);
    chk("queues_empty", beat_q.size() + rsp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
